regfile_arb: RTL and testbench

Two-requester arbiter that shares the single-port register file (one addr, we, d_in, combinational d_out) between master 0 (operand fetch) and master 1 (write-back/loader). Each cycle it picks at most one master with round-robin priority and optional bounded locking. It drives the regfile port from the winner and returns read data one cycle later. It sits between the masters and the regfile instance; the regfile itself is unchanged.

---
 rtl/regfile_arb_pkg.sv | 23 ++
 rtl/regfile_arb_if.sv | 29 ++
 rtl/regfile_arb_rr_pick2.sv | 32 +++
 rtl/regfile_arb.sv | 117 +++++++++++
 tb/tb_regfile_arb.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_arb_pkg.sv
// Shared types and defaults for the register-file arbiter: word/address sizes,
// arbiter state encodings and the hold-counter helper.
package regfile_arb_pkg;

  localparam int ADDRSIZE     = 5;
  localparam int WORDSIZE     = 16;
  localparam int ARB_MAX_HOLD = 4;
  localparam int HOLD_W       = 4;

  localparam logic [HOLD_W-1:0] HOLD_SAT = 4'hF;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_OWN0 = 2'b01,
    ARB_OWN1 = 2'b10
  } arb_state_e;

  // Hold counter stops at its all-ones value instead of wrapping.
  function automatic logic [HOLD_W-1:0] hold_inc(input logic [HOLD_W-1:0] cnt);
    return (cnt == HOLD_SAT) ? cnt : cnt + 1'b1;
  endfunction

endpackage

// File: rtl/regfile_arb_if.sv
// One requester channel into the arbiter: request fields from the master,
// grant and read-return back to it.
interface regfile_arb_if
  import regfile_arb_pkg::*;
#(
  parameter int ADDR_W = ADDRSIZE,
  parameter int WORD_W = WORDSIZE
) ();

  logic              req;
  logic              we;
  logic              lock;
  logic [ADDR_W-1:0] addr;
  logic [WORD_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [WORD_W-1:0] rdata;

  modport master (
    output req, we, lock, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, lock, addr, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/regfile_arb_rr_pick2.sv
// Two-way round-robin picker with an optional current owner that keeps the
// resource while it still requests and its hold budget allows.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       own_valid,
  input  logic       own_id,
  input  logic       hold_ok,
  output logic [1:0] gnt
);

  logic keep;
  logic last_eff;

  always_comb begin
    gnt      = 2'b00;
    keep     = own_valid && req[own_id] && (!req[!own_id] || hold_ok);
    // A preempted or idle owner counts as the most recent winner for the tie.
    last_eff = own_valid ? own_id : last;
    if (keep) begin
      gnt[own_id] = 1'b1;
    end else begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_eff ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/regfile_arb.sv
// Shares one single-port register file between two masters with round-robin
// priority, bounded locking and a one-cycle registered read return.
module regfile_arb
  import regfile_arb_pkg::*;
#(
  parameter int ADDR_W   = ADDRSIZE,
  parameter int WORD_W   = WORDSIZE,
  parameter int MAX_HOLD = ARB_MAX_HOLD
) (
  input  logic              clk,
  input  logic              rst,
  regfile_arb_if.slave      m0,
  regfile_arb_if.slave      m1,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [WORD_W-1:0] rf_din,
  input  logic [WORD_W-1:0] rf_dout
);

  localparam logic [HOLD_W-1:0] MAX_HOLD_C = HOLD_W'(MAX_HOLD);

  arb_state_e        state_q, state_d;
  logic              last_q, last_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [1:0]        rvalid_q, rvalid_d;
  logic [WORD_W-1:0] rdata0_q, rdata0_d;
  logic [WORD_W-1:0] rdata1_q, rdata1_d;

  logic [1:0] pick_gnt;
  logic [1:0] gnt;
  logic       win;
  logic       win_lock;
  arb_state_e own_state;

  rr_pick2 u_pick (
    .req       ({m1.req, m0.req}),
    .last      (last_q),
    .own_valid (state_q != ARB_IDLE),
    .own_id    (state_q == ARB_OWN1),
    .hold_ok   (hold_q < MAX_HOLD_C),
    .gnt       (pick_gnt)
  );

  // Grants and the regfile port are held quiet for the whole reset interval.
  assign gnt = pick_gnt & {2{rst}};

  assign m0.gnt    = gnt[0];
  assign m1.gnt    = gnt[1];
  assign m0.rvalid = rvalid_q[0];
  assign m1.rvalid = rvalid_q[1];
  assign m0.rdata  = rdata0_q;
  assign m1.rdata  = rdata1_q;

  always_comb begin
    rf_we   = 1'b0;
    rf_addr = '0;
    rf_din  = '0;
    if (gnt[0]) begin
      rf_we   = m0.we;
      rf_addr = m0.addr;
      rf_din  = m0.wdata;
    end else if (gnt[1]) begin
      rf_we   = m1.we;
      rf_addr = m1.addr;
      rf_din  = m1.wdata;
    end
  end

  always_comb begin
    state_d   = ARB_IDLE;
    last_d    = last_q;
    hold_d    = '0;
    rvalid_d  = 2'b00;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    win       = gnt[1];
    win_lock  = gnt[1] ? m1.lock : m0.lock;
    own_state = gnt[1] ? ARB_OWN1 : ARB_OWN0;

    if (gnt != 2'b00) begin
      last_d = win;
      if (win_lock) begin
        state_d = own_state;
        hold_d  = (state_q == own_state) ? hold_inc(hold_q) : HOLD_W'(1);
      end
    end

    // Reads sample the regfile output at the end of the grant cycle.
    if (gnt[0] && !m0.we) begin
      rvalid_d[0] = 1'b1;
      rdata0_d    = rf_dout;
    end
    if (gnt[1] && !m1.we) begin
      rvalid_d[1] = 1'b1;
      rdata1_d    = rf_dout;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ARB_IDLE;
      last_q   <= 1'b1;
      hold_q   <= '0;
      rvalid_q <= 2'b00;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      hold_q   <= hold_d;
      rvalid_q <= rvalid_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

endmodule

// File: tb/tb_regfile_arb.sv
// Directed bench for regfile_arb: a small behavioural register file sits on the
// rf port and each step checks grants, regfile drive and read returns.
module tb_regfile_arb;

  logic        clk;
  logic        rst;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [15:0] rf_din;
  logic [15:0] rf_dout;

  int n_cmp = 0;
  int n_bad = 0;

  regfile_arb_if m0_if ();
  regfile_arb_if m1_if ();

  regfile_arb dut (
    .clk     (clk),
    .rst     (rst),
    .m0      (m0_if),
    .m1      (m1_if),
    .rf_we   (rf_we),
    .rf_addr (rf_addr),
    .rf_din  (rf_din),
    .rf_dout (rf_dout)
  );

  // Unwritten locations read back as 0xA000 + address.
  logic [15:0] mem [32];
  bit   [31:0] wr_mask;

  assign rf_dout = wr_mask[rf_addr] ? mem[rf_addr] : (16'hA000 + 16'(rf_addr));

  always @(posedge clk) begin
    if (rf_we) begin
      mem[rf_addr]     <= rf_din;
      wr_mask[rf_addr] <= 1'b1;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic m0_set(input logic req, input logic we, input logic lock,
                        input logic [4:0] addr, input logic [15:0] wdata);
    m0_if.req   = req;
    m0_if.we    = we;
    m0_if.lock  = lock;
    m0_if.addr  = addr;
    m0_if.wdata = wdata;
  endtask

  task automatic m1_set(input logic req, input logic we, input logic lock,
                        input logic [4:0] addr, input logic [15:0] wdata);
    m1_if.req   = req;
    m1_if.we    = we;
    m1_if.lock  = lock;
    m1_if.addr  = addr;
    m1_if.wdata = wdata;
  endtask

  initial begin
    logic [5:0] lock_pat;
    lock_pat = 6'b101111;

    rst = 1'b0;
    m0_set(1'b1, 1'b0, 1'b0, 5'd2, 16'h0);
    m1_set(1'b1, 1'b0, 1'b0, 5'd7, 16'h0);

    // Reset held with both masters requesting.
    for (int i = 0; i < 3; i++) begin
      mid();
      check("rst_m0_gnt", m0_if.gnt, 1'b0);
      check("rst_m1_gnt", m1_if.gnt, 1'b0);
      check("rst_rf_we", rf_we, 1'b0);
      check("rst_rf_addr", rf_addr, 5'd0);
      check("rst_m0_rvalid", m0_if.rvalid, 1'b0);
      check("rst_m0_rdata", m0_if.rdata, 16'h0);
      tick();
    end

    // First tie after reset goes to m0.
    rst = 1'b1;
    mid();
    check("tie_m0_gnt", m0_if.gnt, 1'b1);
    check("tie_m1_gnt", m1_if.gnt, 1'b0);
    check("tie_rf_addr", rf_addr, 5'd2);
    check("tie_rf_we", rf_we, 1'b0);
    tick();
    m0_set(1'b0, 1'b0, 1'b0, 5'd0, 16'h0);

    mid();
    check("c_m1_gnt", m1_if.gnt, 1'b1);
    check("c_m0_gnt", m0_if.gnt, 1'b0);
    check("c_rf_addr", rf_addr, 5'd7);
    check("c_m0_rvalid", m0_if.rvalid, 1'b1);
    check("c_m0_rdata", m0_if.rdata, 16'hA002);
    tick();
    m1_set(1'b0, 1'b0, 1'b0, 5'd0, 16'h0);

    mid();
    check("d_m1_rvalid", m1_if.rvalid, 1'b1);
    check("d_m1_rdata", m1_if.rdata, 16'hA007);
    check("d_m0_rvalid", m0_if.rvalid, 1'b0);
    check("d_m0_gnt", m0_if.gnt, 1'b0);
    check("d_m1_gnt", m1_if.gnt, 1'b0);
    check("d_rf_addr", rf_addr, 5'd0);
    tick();

    // Write 0x1234 to addr 5, then read it back.
    m0_set(1'b1, 1'b1, 1'b0, 5'd5, 16'h1234);
    mid();
    check("wr_m0_gnt", m0_if.gnt, 1'b1);
    check("wr_rf_we", rf_we, 1'b1);
    check("wr_rf_addr", rf_addr, 5'd5);
    check("wr_rf_din", rf_din, 16'h1234);
    tick();
    m0_set(1'b1, 1'b0, 1'b0, 5'd5, 16'h0);
    mid();
    check("rd_m0_gnt", m0_if.gnt, 1'b1);
    check("rd_rf_we", rf_we, 1'b0);
    check("wr_no_rvalid", m0_if.rvalid, 1'b0);
    tick();
    m0_set(1'b0, 1'b0, 1'b0, 5'd0, 16'h0);
    mid();
    check("rd_m0_rvalid", m0_if.rvalid, 1'b1);
    check("rd_m0_rdata", m0_if.rdata, 16'h1234);
    tick();

    // Round robin without lock; last winner was m0 so m1 starts.
    m0_set(1'b1, 1'b0, 1'b0, 5'd1, 16'h0);
    m1_set(1'b1, 1'b0, 1'b0, 5'd9, 16'h0);
    for (int k = 0; k < 4; k++) begin
      mid();
      check("rr_m1_gnt", m1_if.gnt, (k % 2) == 0);
      check("rr_m0_gnt", m0_if.gnt, (k % 2) == 1);
      if (k > 0) begin
        check("rr_m1_rvalid", m1_if.rvalid, ((k - 1) % 2) == 0);
        check("rr_m0_rvalid", m0_if.rvalid, ((k - 1) % 2) == 1);
      end
      tick();
    end

    // m1 writes alone so m0 takes the next tie.
    m0_set(1'b0, 1'b0, 1'b0, 5'd0, 16'h0);
    m1_set(1'b1, 1'b1, 1'b0, 5'd10, 16'h5555);
    mid();
    check("l_m1_gnt", m1_if.gnt, 1'b1);
    check("l_rf_we", rf_we, 1'b1);
    check("l_m0_rvalid", m0_if.rvalid, 1'b1);
    check("l_m1_rvalid", m1_if.rvalid, 1'b0);
    check("l_m0_rdata", m0_if.rdata, 16'hA001);
    check("l_m1_rdata", m1_if.rdata, 16'hA009);
    tick();

    // Locked m0 keeps 4 grants, m1 then wins once, m0 follows.
    m0_set(1'b1, 1'b0, 1'b1, 5'd5, 16'h0);
    m1_set(1'b1, 1'b0, 1'b0, 5'd3, 16'h0);
    for (int j = 0; j < 6; j++) begin
      mid();
      check("lk_m0_gnt", m0_if.gnt, lock_pat[j]);
      check("lk_m1_gnt", m1_if.gnt, !lock_pat[j]);
      if (j == 5) begin
        check("lk_m1_rvalid", m1_if.rvalid, 1'b1);
        check("lk_m1_rdata", m1_if.rdata, 16'hA003);
      end
      tick();
      if (j == 4) m1_set(1'b0, 1'b0, 1'b0, 5'd0, 16'h0);
    end
    m0_set(1'b0, 1'b0, 1'b0, 5'd0, 16'h0);
    mid();
    check("lk_m0_rvalid", m0_if.rvalid, 1'b1);
    check("lk_m0_rdata", m0_if.rdata, 16'h1234);
    tick();

    // Same-address conflict: m1 write beats m0 read, read sees new value.
    m1_set(1'b1, 1'b1, 1'b0, 5'd3, 16'hBEEF);
    m0_set(1'b1, 1'b0, 1'b0, 5'd3, 16'h0);
    mid();
    check("cf_m1_gnt", m1_if.gnt, 1'b1);
    check("cf_m0_gnt", m0_if.gnt, 1'b0);
    check("cf_rf_din", rf_din, 16'hBEEF);
    check("cf_rf_addr", rf_addr, 5'd3);
    tick();
    m1_set(1'b0, 1'b0, 1'b0, 5'd0, 16'h0);
    mid();
    check("cf_m0_gnt2", m0_if.gnt, 1'b1);
    check("cf_rf_addr2", rf_addr, 5'd3);
    tick();
    m0_set(1'b0, 1'b0, 1'b0, 5'd0, 16'h0);
    mid();
    check("cf_m0_rvalid", m0_if.rvalid, 1'b1);
    check("cf_m0_rdata", m0_if.rdata, 16'hBEEF);
    tick();

    // Asynchronous reset between the grant and the capturing edge.
    m0_set(1'b1, 1'b0, 1'b0, 5'd9, 16'h0);
    mid();
    check("ar_m0_gnt", m0_if.gnt, 1'b1);
    #1;
    rst = 1'b0;
    #1;
    check("ar_gnt_forced", m0_if.gnt, 1'b0);
    check("ar_rdata_clr", m0_if.rdata, 16'h0);
    tick();
    check("ar_no_rvalid", m0_if.rvalid, 1'b0);
    rst = 1'b1;
    m0_set(1'b1, 1'b0, 1'b0, 5'd4, 16'h0);
    m1_set(1'b1, 1'b0, 1'b0, 5'd6, 16'h0);
    mid();
    check("ar_tie_m0", m0_if.gnt, 1'b1);
    check("ar_tie_m1", m1_if.gnt, 1'b0);
    tick();
    m0_set(1'b0, 1'b0, 1'b0, 5'd0, 16'h0);
    mid();
    check("ar_m0_rvalid", m0_if.rvalid, 1'b1);
    check("ar_m0_rdata", m0_if.rdata, 16'hA004);
    check("ar_m1_gnt", m1_if.gnt, 1'b1);
    tick();
    m1_set(1'b0, 1'b0, 1'b0, 5'd0, 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
